// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: 8-digit common-anode seven-segment scanner.
// Walks digits with a blanking guard; frame-aligned, tear-free value updates.
module sseg_scan_driver #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 100,
  parameter int LZ_SUPPRESS  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic                    update,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [3:0]              bcd_out,
  output logic [N_DIGITS-1:0]     anodes_n,
  output logic                    dp_n,
  output logic [2:0]              digit_idx
);

  localparam int CNT_MAX =
    (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int PW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int IW = $clog2(N_DIGITS);

  typedef enum logic {
    SHOW,
    GUARD
  } state_t;

  state_t                  state;
  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   shadow;
  logic [4*N_DIGITS-1:0]   disp;
  logic                    pending;

  logic [N_DIGITS-1:0]     upper_zero;
  logic [N_DIGITS-1:0]     suppress;
  logic                    lit;
  logic                    last_digit;
  logic [N_DIGITS-1:0]     an_next;
  logic [3:0]              nib;

  // Digit i is blank-eligible when it and every higher nibble are zero.
  always_comb begin
    upper_zero = '0;
    suppress   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      upper_zero[i] = ((disp >> (4 * i)) == '0);
      if (LZ_SUPPRESS != 0 && i > 0) begin
        suppress[i] = upper_zero[i];
      end
    end
  end

  // Next output values from current state, index and live enables.
  always_comb begin
    last_digit = (idx == IW'(N_DIGITS - 1));
    nib        = disp[4*idx +: 4];
    lit        = (state == SHOW) && digit_en[idx] && !suppress[idx];
    an_next    = '1;
    if (lit) begin
      an_next[idx] = 1'b0;
    end
  end

  // Scan FSM, frame-aligned display load and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SHOW;
      presc     <= '0;
      idx       <= '0;
      shadow    <= '0;
      disp      <= '0;
      pending   <= 1'b0;
      anodes_n  <= '1;
      bcd_out   <= 4'h0;
      dp_n      <= 1'b1;
      digit_idx <= 3'd0;
    end else begin
      if (update) begin
        shadow  <= value;
        pending <= 1'b1;
      end
      unique case (state)
        SHOW: begin
          if (presc == PW'(REFRESH_DIV - 1)) begin
            state <= GUARD;
            presc <= '0;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        GUARD: begin
          if (presc == PW'(GUARD_CYCLES - 1)) begin
            state <= SHOW;
            presc <= '0;
            if (last_digit) begin
              idx     <= '0;
              pending <= 1'b0;
              if (update) begin
                disp <= value;
              end else if (pending) begin
                disp <= shadow;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
      endcase
      anodes_n  <= an_next;
      bcd_out   <= nib;
      dp_n      <= ~(dp_in[idx] & lit);
      digit_idx <= 3'(idx);
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed scan, update, enable, LZ and reset checks.
// Two instances share stimulus; one plain, one with leading-zero blanking.
module tb_sseg_scan_driver;

  logic        clk;
  logic        reset_n;
  logic [31:0] value;
  logic        update;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;

  logic [3:0]  bcd_a, bcd_b;
  logic [7:0]  an_a, an_b;
  logic        dp_a, dp_b;
  logic [2:0]  idx_a, idx_b;

  int vectors;
  int miscompares;
  int fr;

  sseg_scan_driver #(
    .N_DIGITS(8), .REFRESH_DIV(4), .GUARD_CYCLES(1), .LZ_SUPPRESS(0)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .value(value), .update(update),
    .digit_en(digit_en), .dp_in(dp_in), .bcd_out(bcd_a),
    .anodes_n(an_a), .dp_n(dp_a), .digit_idx(idx_a)
  );

  sseg_scan_driver #(
    .N_DIGITS(8), .REFRESH_DIV(4), .GUARD_CYCLES(1), .LZ_SUPPRESS(1)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .value(value), .update(update),
    .digit_en(digit_en), .dp_in(dp_in), .bcd_out(bcd_b),
    .anodes_n(an_b), .dp_n(dp_b), .digit_idx(idx_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slot(input int k, input logic [3:0] eb, input bit act,
                      input bit edp, input int upd_at,
                      input logic [31:0] upd_val, input bit use_b);
    logic [7:0] an, exp_an;
    logic [3:0] bcd;
    logic       dp, exp_dp;
    logic [2:0] ix;
    string      tg;
    for (int t = 0; t < 5; t++) begin
      if (t == upd_at) begin
        value  = upd_val;
        update = 1'b1;
      end
      tick();
      an  = use_b ? an_b  : an_a;
      bcd = use_b ? bcd_b : bcd_a;
      dp  = use_b ? dp_b  : dp_a;
      ix  = use_b ? idx_b : idx_a;
      if (t < 4) begin
        exp_an = act ? ~(8'h01 << k) : 8'hFF;
        exp_dp = ~(edp & act);
      end else begin
        exp_an = 8'hFF;
        exp_dp = 1'b1;
      end
      tg = $sformatf("f%0d d%0d t%0d", fr, k, t);
      chk({tg, " anodes"}, an, exp_an);
      chk({tg, " bcd"}, {4'h0, bcd}, {4'h0, eb});
      chk({tg, " dp"}, {7'h0, dp}, {7'h0, exp_dp});
      chk({tg, " idx"}, {5'h0, ix}, 8'(k));
      chk({tg, " onehot"},
          {7'h0, (an == 8'hFF) || $onehot(~an)}, 8'd1);
    end
  endtask

  task automatic frame(input logic [31:0] ev, input logic [7:0] en,
                       input logic [7:0] dp, input bit use_b,
                       input int upd_digit, input int upd_at,
                       input logic [31:0] upd_val);
    bit act;
    for (int k = 0; k < 8; k++) begin
      act = en[k] && !(use_b && k > 0 && ((ev >> (4 * k)) == 32'h0));
      slot(k, ev[4*k +: 4], act, dp[k],
           (k == upd_digit) ? upd_at : -1, upd_val, use_b);
    end
    fr++;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fr          = 0;
    clk         = 1'b0;
    reset_n     = 1'b0;
    value       = 32'h0;
    update      = 1'b0;
    digit_en    = 8'hFF;
    dp_in       = 8'h00;

    repeat (3) tick();
    chk("rst anodes_a", an_a, 8'hFF);
    chk("rst bcd_a", {4'h0, bcd_a}, 8'h00);
    chk("rst dp_a", {7'h0, dp_a}, 8'h01);
    chk("rst idx_a", {5'h0, idx_a}, 8'h00);
    chk("rst anodes_b", an_b, 8'hFF);
    chk("rst bcd_b", {4'h0, bcd_b}, 8'h00);

    reset_n = 1'b1;
    frame(32'h0, 8'hFF, 8'h00, 0, 2, 1, 32'h89ABCDEF);
    frame(32'h89ABCDEF, 8'hFF, 8'h00, 0, -1, 0, 32'h0);
    frame(32'h89ABCDEF, 8'hFF, 8'h00, 0, -1, 0, 32'h0);
    frame(32'h89ABCDEF, 8'hFF, 8'h00, 0, 5, 0, 32'h11111111);
    frame(32'h11111111, 8'hFF, 8'h00, 0, 3, 2, 32'h22222222);
    frame(32'h22222222, 8'hFF, 8'h00, 0, 7, 4, 32'h33333333);
    frame(32'h33333333, 8'hFF, 8'h00, 0, -1, 0, 32'h0);

    digit_en = 8'b0000_0101;
    dp_in    = 8'h01;
    frame(32'h33333333, 8'h05, 8'h01, 0, 7, 4, 32'h00000305);
    digit_en = 8'hFF;
    dp_in    = 8'h00;

    frame(32'h00000305, 8'hFF, 8'h00, 1, 7, 4, 32'h00000000);
    frame(32'h00000000, 8'hFF, 8'h00, 1, 7, 4, 32'h76543210);

    for (int k = 0; k < 5; k++) begin
      slot(k, 4'(k), 1'b1, 1'b0, -1, 32'h0, 1'b0);
    end
    tick();
    chk("d5 lit anodes", an_a, 8'hDF);
    chk("d5 lit bcd", {4'h0, bcd_a}, 8'h05);
    tick();
    chk("d5 lit2 anodes", an_a, 8'hDF);
    reset_n = 1'b0;
    tick();
    chk("midrst anodes", an_a, 8'hFF);
    chk("midrst idx", {5'h0, idx_a}, 8'h00);
    chk("midrst bcd", {4'h0, bcd_a}, 8'h00);
    chk("midrst dp", {7'h0, dp_a}, 8'h01);
    reset_n = 1'b1;
    fr++;
    frame(32'h0, 8'hFF, 8'h00, 0, -1, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
